// File: rtl/kbd_pkg.sv
// Shared keyboard-decoder definitions: PS/2 prefix bytes, keypad codes,
// the prefix-FSM states, the queued event record, and the scancode lookup.
package kbd_pkg;

  localparam logic [7:0] PFX_EXT  = 8'hE0;
  localparam logic [7:0] PFX_BRK  = 8'hF0;
  localparam logic [7:0] BYTE_NUL = 8'h00;

  localparam int CODE_W = 4;
  typedef logic [CODE_W-1:0] code_t;

  localparam code_t KEY_0     = 4'd0;
  localparam code_t KEY_1     = 4'd1;
  localparam code_t KEY_2     = 4'd2;
  localparam code_t KEY_3     = 4'd3;
  localparam code_t KEY_4     = 4'd4;
  localparam code_t KEY_5     = 4'd5;
  localparam code_t KEY_6     = 4'd6;
  localparam code_t KEY_7     = 4'd7;
  localparam code_t KEY_8     = 4'd8;
  localparam code_t KEY_9     = 4'd9;
  localparam code_t KEY_MINUS = 4'd10;
  localparam code_t KEY_PLUS  = 4'd11;
  localparam code_t KEY_STAR  = 4'd12;
  localparam code_t KEY_SLASH = 4'd13;
  localparam code_t KEY_ENTER = 4'd14;
  localparam code_t KEY_ERR   = 4'd15;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  typedef struct packed {
    code_t code;
    logic  brk;
    logic  ext;
  } kbd_event_t;

  function automatic code_t lookup_code(input logic [7:0] byte_in, input logic ext);
    code_t c;
    c = KEY_ERR;
    if (ext) begin
      case (byte_in)
        8'h4A:   c = KEY_SLASH;
        8'h5A:   c = KEY_ENTER;
        default: c = KEY_ERR;
      endcase
    end else begin
      case (byte_in)
        8'h16:   c = KEY_1;
        8'h1E:   c = KEY_2;
        8'h26:   c = KEY_3;
        8'h25:   c = KEY_4;
        8'h2E:   c = KEY_5;
        8'h36:   c = KEY_6;
        8'h3D:   c = KEY_7;
        8'h3E:   c = KEY_8;
        8'h46:   c = KEY_9;
        8'h45:   c = KEY_0;
        8'h4E:   c = KEY_MINUS;
        8'h55:   c = KEY_PLUS;
        8'h7C:   c = KEY_STAR;
        8'h5A:   c = KEY_ENTER;
        default: c = KEY_ERR;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Power-of-two circular event FIFO; a push into a full FIFO succeeds only
// when a pop retires the head on the same edge, otherwise it is reported as dropped.
module kbd_event_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [5:0]
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  T                     wr_data,
  input  logic                 pop_req,
  output T                     head,
  output logic                 empty,
  output logic                 drop,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          full, do_push, do_pop;
  T              mem_q [DEPTH];

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    do_pop   = pop_req && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; occupancy tracking alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/scancode_event_decoder.sv
// PS/2 keypad scancode decoder: tracks E0/F0 prefixes, maps bytes to keypad
// codes and queues make/break events for a ready/valid consumer.
module scancode_event_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int OUT_W        = 4,
  parameter int REPORT_BREAK = 0,
  parameter int DROP_UNKNOWN = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  scan_code_in,
  input  logic                        scan_valid_in,
  output logic [OUT_W-1:0]            key_code_out,
  output logic                        key_break_out,
  output logic                        key_ext_out,
  output logic                        key_valid_out,
  input  logic                        key_ready_in,
  output logic                        overflow_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (OUT_W < CODE_W) begin : g_bad_width
    $error("OUT_W must be at least 4");
  end

  state_e     state_q, state_d;
  kbd_event_t evt_d;
  logic       emit, push;
  logic       overflow_q, overflow_d;
  kbd_event_t head;
  logic       fifo_empty, fifo_drop;

  always_comb begin
    state_d = state_q;
    evt_d   = '0;
    emit    = 1'b0;
    if (scan_valid_in) begin
      // A NUL byte is a line error: reported on its own, prefix state kept.
      if (scan_code_in == BYTE_NUL) begin
        emit       = 1'b1;
        evt_d.code = KEY_ERR;
      end else begin
        case (state_q)
          IDLE: begin
            if (scan_code_in == PFX_EXT)      state_d = EXT;
            else if (scan_code_in == PFX_BRK) state_d = BRK;
            else begin
              emit       = 1'b1;
              evt_d.code = lookup_code(scan_code_in, 1'b0);
            end
          end
          EXT: begin
            if (scan_code_in == PFX_BRK)      state_d = EXT_BRK;
            else if (scan_code_in != PFX_EXT) begin
              emit       = 1'b1;
              evt_d.code = lookup_code(scan_code_in, 1'b1);
              evt_d.ext  = 1'b1;
              state_d    = IDLE;
            end
          end
          BRK: begin
            emit       = 1'b1;
            evt_d.code = lookup_code(scan_code_in, 1'b0);
            evt_d.brk  = 1'b1;
            state_d    = IDLE;
          end
          default: begin
            emit       = 1'b1;
            evt_d.code = lookup_code(scan_code_in, 1'b1);
            evt_d.brk  = 1'b1;
            evt_d.ext  = 1'b1;
            state_d    = IDLE;
          end
        endcase
      end
    end
    push = emit
        && !(evt_d.brk && (REPORT_BREAK == 0))
        && !((evt_d.code == KEY_ERR) && (DROP_UNKNOWN != 0));
  end

  assign overflow_d = fifo_drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (kbd_event_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (evt_d),
    .pop_req (key_ready_in),
    .head    (head),
    .empty   (fifo_empty),
    .drop    (fifo_drop),
    .count   (fifo_count_out)
  );

  assign key_valid_out = !fifo_empty;
  assign key_code_out  = fifo_empty ? '0 : OUT_W'(head.code);
  assign key_break_out = !fifo_empty && head.brk;
  assign key_ext_out   = !fifo_empty && head.ext;
  assign overflow_out  = overflow_q;

endmodule

// File: tb/tb_scancode_event_decoder.sv
// Scoreboard bench: two decoder instances share one byte stream, one with
// defaults and one reporting breaks with a wider code output.
module tb_scancode_event_decoder;

  typedef struct packed {
    logic [3:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       ready;

  logic [3:0] a_code;
  logic       a_brk, a_ext, a_valid, a_ovf;
  logic [2:0] a_cnt;
  logic [5:0] b_code;
  logic       b_brk, b_ext, b_valid, b_ovf;
  logic [2:0] b_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  int   ovf_a = 0;
  int   ovf_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  logic [7:0] map_byte [14] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h7C, 8'h5A};
  logic [3:0] map_code [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                4'd8, 4'd9, 4'd0, 4'd10, 4'd11, 4'd12, 4'd14};

  scancode_event_decoder #(
    .FIFO_DEPTH(4), .OUT_W(4), .REPORT_BREAK(0), .DROP_UNKNOWN(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .scan_code_in(scan_code), .scan_valid_in(scan_valid),
    .key_code_out(a_code), .key_break_out(a_brk), .key_ext_out(a_ext),
    .key_valid_out(a_valid), .key_ready_in(ready), .overflow_out(a_ovf),
    .fifo_count_out(a_cnt)
  );

  scancode_event_decoder #(
    .FIFO_DEPTH(4), .OUT_W(6), .REPORT_BREAK(1), .DROP_UNKNOWN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .scan_code_in(scan_code), .scan_valid_in(scan_valid),
    .key_code_out(b_code), .key_break_out(b_brk), .key_ext_out(b_ext),
    .key_valid_out(b_valid), .key_ready_in(ready), .overflow_out(b_ovf),
    .fifo_count_out(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] c, input logic brk, input logic ext);
    exp_t e;
    e.code = c;
    e.brk  = brk;
    e.ext  = ext;
    return e;
  endfunction

  // Every accepted head is compared against the front of its instance's queue.
  initial forever begin
    @(negedge clk);
    if (a_ovf === 1'b1) ovf_a++;
    if (b_ovf === 1'b1) ovf_b++;
    if (ready && a_valid) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL sb_a_extra got code=%0d brk=%0b ext=%0b required no event", a_code, a_brk, a_ext);
      end else begin
        ea = qa.pop_front();
        if ({a_code, a_brk, a_ext} !== {ea.code, ea.brk, ea.ext}) begin
          n_err++;
          $display("FAIL sb_a_event got code=%0d brk=%0b ext=%0b required code=%0d brk=%0b ext=%0b",
                   a_code, a_brk, a_ext, ea.code, ea.brk, ea.ext);
        end
      end
    end
    if (ready && b_valid) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL sb_b_extra got code=%0d brk=%0b ext=%0b required no event", b_code, b_brk, b_ext);
      end else begin
        eb = qb.pop_front();
        if ({b_code, b_brk, b_ext} !== {2'b00, eb.code, eb.brk, eb.ext}) begin
          n_err++;
          $display("FAIL sb_b_event got code=%0d brk=%0b ext=%0b required code=%0d brk=%0b ext=%0b",
                   b_code, b_brk, b_ext, eb.code, eb.brk, eb.ext);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic drain;
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && !a_valid && !b_valid) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ready = 1'b1; scan_valid = 1'b1; scan_code = 8'h16;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({a_valid, a_code, a_brk, a_ext, a_ovf, a_cnt} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_a got valid=%0b code=%0d brk=%0b ext=%0b ovf=%0b cnt=%0d required all 0",
               a_valid, a_code, a_brk, a_ext, a_ovf, a_cnt);
    end
    n_vec++;
    if ({b_valid, b_code, b_brk, b_ext, b_ovf, b_cnt} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_b got valid=%0b code=%0d brk=%0b ext=%0b ovf=%0b cnt=%0d required all 0",
               b_valid, b_code, b_brk, b_ext, b_ovf, b_cnt);
    end
    rst_n = 1'b1; scan_valid = 1'b0; scan_code = 8'h00;
    @(negedge clk);
    n_vec++;
    if (a_cnt !== 3'd0 || a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty_ready_a got cnt=%0d valid=%0b required cnt=0 valid=0", a_cnt, a_valid);
    end
    @(posedge clk);
    #1;
    qa.push_back(mk(4'd1, 1'b0, 1'b0));
    qb.push_back(mk(4'd1, 1'b0, 1'b0));
    scan_code = 8'h16; scan_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early got valid=%0b required 0 during strobe cycle", a_valid);
    end
    @(posedge clk);
    #1;
    scan_valid = 1'b0; scan_code = 8'h00;
    @(negedge clk);
    n_vec++;
    if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency_one got valid_a=%0b valid_b=%0b required 1 1", a_valid, b_valid);
    end
    @(negedge clk);
    n_vec++;
    if (a_valid !== 1'b0 || a_code !== 4'd0 || a_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL idle_zero got valid=%0b code=%0d cnt=%0d required 0 0 0", a_valid, a_code, a_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_break_filter;
    ready = 1'b1;
    qa.push_back(mk(4'd2, 1'b0, 1'b0));
    qb.push_back(mk(4'd2, 1'b0, 1'b0));
    qb.push_back(mk(4'd2, 1'b1, 1'b0));
    send(8'h1E); send(8'hF0); send(8'h1E);
    drain;
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL break_drain got pending_a=%0d pending_b=%0d required 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_extended;
    ready = 1'b1;
    qa.push_back(mk(4'd13, 1'b0, 1'b1));
    qa.push_back(mk(4'd15, 1'b0, 1'b1));
    qb.push_back(mk(4'd13, 1'b0, 1'b1));
    qb.push_back(mk(4'd13, 1'b1, 1'b1));
    qb.push_back(mk(4'd15, 1'b0, 1'b1));
    send(8'hE0); send(8'h4A);
    send(8'hE0); send(8'hF0); send(8'h4A);
    send(8'hE0); send(8'h12);
    drain;
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL ext_drain got pending_a=%0d pending_b=%0d required 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_back_to_back;
    ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      qa.push_back(mk(map_code[i], 1'b0, 1'b0));
      qb.push_back(mk(map_code[i], 1'b0, 1'b0));
      send(map_byte[i]);
    end
    for (int i = 0; i < 3; i++) begin
      qa.push_back(mk(4'd1, 1'b0, 1'b0));
      qb.push_back(mk(4'd1, 1'b0, 1'b0));
      send(8'h16);
    end
    qa.push_back(mk(4'd15, 1'b0, 1'b0)); qb.push_back(mk(4'd15, 1'b0, 1'b0));
    send(8'h00);
    qa.push_back(mk(4'd15, 1'b0, 1'b0)); qb.push_back(mk(4'd15, 1'b0, 1'b0));
    send(8'h1C);
    qa.push_back(mk(4'd14, 1'b0, 1'b1)); qb.push_back(mk(4'd14, 1'b0, 1'b1));
    send(8'hE0); send(8'h5A);
    drain;
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL map_drain got pending_a=%0d pending_b=%0d required 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_overflow;
    ready = 1'b0;
    ovf_a = 0; ovf_b = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        qa.push_back(mk(map_code[i], 1'b0, 1'b0));
        qb.push_back(mk(map_code[i], 1'b0, 1'b0));
      end
      send(map_byte[i]);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_cnt !== 3'd4 || b_cnt !== 3'd4) begin
      n_err++;
      $display("FAIL ovf_count got cnt_a=%0d cnt_b=%0d required 4 4", a_cnt, b_cnt);
    end
    n_vec++;
    if (ovf_a != 1 || ovf_b != 1) begin
      n_err++;
      $display("FAIL ovf_pulse got pulses_a=%0d pulses_b=%0d required 1 1", ovf_a, ovf_b);
    end
    @(posedge clk);
    #1;
    drain;
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0 || a_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL ovf_drain got pending_a=%0d pending_b=%0d cnt=%0d required 0 0 0",
               qa.size(), qb.size(), a_cnt);
    end
  endtask

  task automatic test_full_push_pop;
    ready = 1'b0;
    for (int i = 2; i < 6; i++) begin
      qa.push_back(mk(map_code[i], 1'b0, 1'b0));
      qb.push_back(mk(map_code[i], 1'b0, 1'b0));
      send(map_byte[i]);
    end
    n_vec++;
    if (a_cnt !== 3'd4) begin
      n_err++;
      $display("FAIL full_fill got cnt=%0d required 4", a_cnt);
    end
    qa.push_back(mk(4'd7, 1'b0, 1'b0));
    qb.push_back(mk(4'd7, 1'b0, 1'b0));
    scan_code = 8'h3D; scan_valid = 1'b1; ready = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0; scan_code = 8'h00; ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_cnt !== 3'd4 || b_cnt !== 3'd4 || a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop got cnt_a=%0d cnt_b=%0d ovf_a=%0b ovf_b=%0b required 4 4 0 0",
               a_cnt, b_cnt, a_ovf, b_ovf);
    end
    @(posedge clk);
    #1;
    drain;
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL full_drain got pending_a=%0d pending_b=%0d required 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_mid_reset;
    ready = 1'b0;
    send(8'h16);
    send(8'hE0);
    rst_n = 1'b0; scan_code = 8'h26; scan_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1; scan_valid = 1'b0; scan_code = 8'h00;
    n_vec++;
    if (a_cnt !== 3'd0 || b_cnt !== 3'd0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_flush got cnt_a=%0d cnt_b=%0d valid_a=%0b valid_b=%0b required 0 0 0 0",
               a_cnt, b_cnt, a_valid, b_valid);
    end
    ready = 1'b1;
    qa.push_back(mk(4'd15, 1'b0, 1'b0));
    qb.push_back(mk(4'd15, 1'b0, 1'b0));
    send(8'h4A);
    drain;
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL midrst_drain got pending_a=%0d pending_b=%0d required 0 0", qa.size(), qb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; scan_code = 8'h00; scan_valid = 1'b0; ready = 1'b0;
    test_reset;
    test_break_filter;
    test_extended;
    test_back_to_back;
    test_overflow;
    test_full_push_pop;
    test_mid_reset;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scancode_event_decoder.md
SCANCODE_EVENT_DECODER -- requirements
Module: scancode_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter OUT_W, default 4, meaning key code width; values below 4 are illegal.
REQ-003 SHALL have parameter REPORT_BREAK, default 0, meaning 1 = key-release events are queued and 0 = they are discarded.
REQ-004 SHALL have parameter DROP_UNKNOWN, default 0, meaning 1 = unmapped codes are discarded and 0 = they are queued as ERROR.
REQ-005 SHALL provide clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL provide rst_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL provide scan_code_in, input, 8, a received PS/2 byte.
REQ-008 SHALL provide scan_valid_in, input, 1, a one-cycle strobe qualifying scan_code_in.
REQ-009 SHALL provide key_code_out, output, OUT_W, the decoded code at the FIFO head, zero-extended.
REQ-010 SHALL provide key_break_out, output, 1, which is 1 when the head event is a release.
REQ-011 SHALL provide key_ext_out, output, 1, which is 1 when the head event was E0-prefixed.
REQ-012 SHALL provide key_valid_out, output, 1, which is 1 while the FIFO is non-empty.
REQ-013 SHALL provide key_ready_in, input, 1, the consumer accept signal.
REQ-014 SHALL provide overflow_out, output, 1, a one-cycle pulse issued when a decoded event is lost.
REQ-015 SHALL provide fifo_count_out, output, $clog2(FIFO_DEPTH)+1 bits, the current occupancy.

Function
REQ-016 SHALL map non-extended codes as follows: 16/1E/26/25/2E/36/3D/3E/46/45 -> 1..9,0; 4E -> 10 ('-'); 55 -> 11 ('+'); 7C -> 12 ('*'); 5A -> 14 (Enter).
REQ-017 SHALL map extended (E0) codes as follows: 4A -> 13 ('/'); 5A -> 14 (keypad Enter); every other extended code is unknown.
REQ-018 SHALL encode unknown codes as ERROR, code 15.
REQ-019 SHALL implement a prefix FSM with states IDLE, EXT, BRK and EXT_BRK, advancing only on cycles with scan_valid_in=1.
REQ-020 SHALL apply these FSM transitions:
- IDLE: E0 -> EXT; F0 -> BRK; any other byte emits a make event and stays in IDLE.
- EXT: F0 -> EXT_BRK; E0 stays in EXT; any other byte emits an extended make event and goes to IDLE.
- BRK: any byte emits a break event and goes to IDLE.
- EXT_BRK: any byte emits an extended break event and goes to IDLE.
REQ-021 SHALL treat byte 00 in any state as ERROR with no state change; it SHALL be queued unless DROP_UNKNOWN=1.
REQ-022 SHALL discard emitted break events when REPORT_BREAK=0.
REQ-023 SHALL discard emitted unknown events when DROP_UNKNOWN=1.
REQ-024 SHALL write each event to the FIFO on the same edge its final byte is sampled, so key_valid_out rises one cycle after the strobe when the FIFO was empty; there is no combinational bypass.
REQ-025 SHALL pop the FIFO on any edge where key_valid_out=1 and key_ready_in=1.
REQ-026 SHALL hold key_code_out, key_break_out and key_ext_out stable while key_valid_out=1 and key_ready_in=0.
REQ-027 SHALL accept a push when the FIFO is full only if a pop occurs on the same edge; otherwise the event is dropped and overflow_out pulses on the next cycle.
REQ-028 SHALL leave the FIFO count unchanged on a simultaneous push and pop at any occupancy.
REQ-029 SHALL ignore key_ready_in when the FIFO is empty; the count never underflows.
REQ-030 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-031 SHALL deliver typematic repeats (repeated make codes) as separate events.
REQ-032 SHALL drive key_code_out, key_break_out and key_ext_out to 0 whenever key_valid_out=0.

Reset
REQ-033 SHALL, on a clk edge with rst_n=0, put the FSM in IDLE, empty the FIFO, and drive key_valid_out=0, key_code_out=0, key_break_out=0, key_ext_out=0, overflow_out=0 and fifo_count_out=0.
REQ-034 SHALL abandon any pending prefix and all queued events when reset is asserted mid-sequence; it SHALL ignore scan_valid_in while rst_n=0.

Structure
REQ-035 SHALL place the following in shared package kbd_pkg: the prefix constants (E0, F0), the code constants (0-9, 10..15), the FSM state enum, and the event struct {code, brk, ext}.
REQ-036 SHALL implement the FIFO as sub-module kbd_event_fifo, parametrised by depth and element type, with its own synchronous active-low reset.
REQ-037 SHALL keep the code lookup as a package function.

Verification
REQ-038 SHALL include a reset scenario: defaults, key_ready_in=1, stream 16 -> code 1 with brk=0, ext=0, valid exactly one cycle after the strobe.
REQ-039 SHALL include a break-filter scenario: REPORT_BREAK=0, stream 1E F0 1E -> one event, code 2; with REPORT_BREAK=1 -> two events (2,brk=0), (2,brk=1).
REQ-040 SHALL include an extended scenario: stream E0 4A, E0 F0 4A, E0 12 -> (13,ext=1), (13,ext=1,brk=1) when REPORT_BREAK=1, then (15,ext=1).
REQ-041 SHALL include an overflow scenario: FIFO_DEPTH=4, key_ready_in=0, five make codes -> count=4, one overflow pulse, first four events retained in order.
REQ-042 SHALL include a full-FIFO simultaneous push/pop scenario: full FIFO, key_ready_in=1 on the same edge as a new strobe -> no overflow, count stays 4, new event appears last.
REQ-043 SHALL include a mid-sequence reset scenario: E0, then rst_n=0 for one edge, then 4A -> event (15,ext=0) with DROP_UNKNOWN=0.
